// File: rtl/nabp_swap_control.sv
// -----------------------------------------------------------------------------
// nabp_swap_control
//
// Responder side of the swap / next-iteration handshake between two identical,
// swappable processing units (A and B) and the shared PE array.
//
//   * next_itr: the requesting unit is given the accumulator parameters of the
//     next projection angle. They are read from an external angle LUT with one
//     cycle of read latency. When both units request, the unit that is not
//     driving the PEs (the filler) is served first.
//   * swap: acknowledged only when both units request it. pe_sel then flips
//     which unit drives the PE array.
//   * done: pulses once every angle has been issued and both units ask for
//     another iteration, meaning both are drained.
//
// Ports
//   clk, reset_n            clock and synchronous active-low reset
//   kick                    start a run (only looked at while idle)
//   busy, done              run in progress / one-cycle end-of-run pulse
//   lut_angle               LUT address; LUT data is valid one cycle later
//   lut_sh_accu_base,
//   lut_mp_accu_init,
//   lut_mp_accu_base        LUT read data
//   {a,b}_swap,
//   {a,b}_next_itr          level requests, held until acknowledged
//   {a,b}_pe_en             PE enable from each unit
//   {a,b}_swap_ack,
//   {a,b}_next_itr_ack      one-cycle acknowledges
//   {a,b}_sh_accu_base,
//   {a,b}_mp_accu_init,
//   {a,b}_mp_accu_base      per-unit parameter registers
//   pe_sel                  0: unit A drives the PEs, 1: unit B
//   pe_en                   registered PE enable of the selected unit
// -----------------------------------------------------------------------------
module nabp_swap_control #(
  parameter int pNoAngles    = 180,
  parameter int pAngleWidth  = 8,
  parameter int pShBaseWidth = 16,
  parameter int pMpInitWidth = 16,
  parameter int pMpBaseWidth = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    kick,
  output logic                    busy,
  output logic                    done,

  output logic [pAngleWidth-1:0]  lut_angle,
  input  logic [pShBaseWidth-1:0] lut_sh_accu_base,
  input  logic [pMpInitWidth-1:0] lut_mp_accu_init,
  input  logic [pMpBaseWidth-1:0] lut_mp_accu_base,

  input  logic                    a_swap,
  input  logic                    a_next_itr,
  input  logic                    a_pe_en,
  output logic                    a_swap_ack,
  output logic                    a_next_itr_ack,
  output logic [pShBaseWidth-1:0] a_sh_accu_base,
  output logic [pMpInitWidth-1:0] a_mp_accu_init,
  output logic [pMpBaseWidth-1:0] a_mp_accu_base,

  input  logic                    b_swap,
  input  logic                    b_next_itr,
  input  logic                    b_pe_en,
  output logic                    b_swap_ack,
  output logic                    b_next_itr_ack,
  output logic [pShBaseWidth-1:0] b_sh_accu_base,
  output logic [pMpInitWidth-1:0] b_mp_accu_init,
  output logic [pMpBaseWidth-1:0] b_mp_accu_base,

  output logic                    pe_sel,
  output logic                    pe_en
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;
  localparam logic [2:0] ST_SWAP  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [pAngleWidth-1:0] LAST_ANGLE = pAngleWidth'(pNoAngles);

  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [pAngleWidth-1:0] angle_cnt;
  logic                   tgt;          // unit being served by the current fetch: 0 = A, 1 = B

  logic both_next;
  logic any_next;
  logic both_swap;
  logic angles_left;
  logic angles_spent;

  logic start_run;
  logic start_fetch;
  logic start_swap;
  logic start_done;

  assign both_next    = a_next_itr & b_next_itr;
  assign any_next     = a_next_itr | b_next_itr;
  assign both_swap    = a_swap & b_swap;
  assign angles_left  = (angle_cnt < LAST_ANGLE);
  assign angles_spent = (angle_cnt == LAST_ANGLE);

  // ---------------------------------------------------------------------------
  // Next-state decode. Requests are looked at only in WAIT, so a request still
  // held high during ACK or SWAP cannot be served twice.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    state_nxt   = state;
    start_run   = 1'b0;
    start_fetch = 1'b0;
    start_swap  = 1'b0;
    start_done  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (kick) begin
          start_run = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Ending a run outranks serving, serving outranks swapping.
        if (angles_spent && both_next) begin
          start_done = 1'b1;
          state_nxt  = ST_DONE;
        end else if (angles_left && any_next) begin
          start_fetch = 1'b1;
          state_nxt   = ST_FETCH;
        end else if (both_swap) begin
          start_swap = 1'b1;
          state_nxt  = ST_SWAP;
        end
      end
      ST_FETCH: state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_WAIT;
      ST_SWAP:  state_nxt = ST_WAIT;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer registers. All outputs are registered. The one-cycle pulses are
  // cleared every cycle and set on the transition into the cycle where they
  // must be visible.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (!reset_n) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      angle_cnt      <= '0;
      tgt            <= 1'b0;
      lut_angle      <= '0;
      pe_sel         <= 1'b0;
      a_swap_ack     <= 1'b0;
      b_swap_ack     <= 1'b0;
      a_next_itr_ack <= 1'b0;
      b_next_itr_ack <= 1'b0;
    end else begin
      state          <= state_nxt;
      busy           <= (state_nxt != ST_IDLE);
      done           <= start_done;
      a_swap_ack     <= start_swap;
      b_swap_ack     <= start_swap;
      a_next_itr_ack <= 1'b0;
      b_next_itr_ack <= 1'b0;

      if (start_run) begin
        angle_cnt <= '0;
        pe_sel    <= 1'b0;
      end

      if (start_fetch) begin
        // With both units asking, serve the filler so the unit driving the
        // PEs keeps its current parameters until the next swap.
        tgt       <= both_next ? ~pe_sel : b_next_itr;
        lut_angle <= angle_cnt;
      end

      // The new pe_sel is already visible in the SWAP cycle.
      if (start_swap) begin
        pe_sel <= ~pe_sel;
      end

      if (state == ST_LATCH) begin
        angle_cnt      <= angle_cnt + 1'b1;
        a_next_itr_ack <= ~tgt;
        b_next_itr_ack <= tgt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-unit parameter registers. LUT data addressed in FETCH is valid in
  // LATCH, so that is the only cycle they load. They hold across swaps.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_sh_accu_base <= '0;
      a_mp_accu_init <= '0;
      a_mp_accu_base <= '0;
      b_sh_accu_base <= '0;
      b_mp_accu_init <= '0;
      b_mp_accu_base <= '0;
    end else if (state == ST_LATCH) begin
      if (tgt) begin
        b_sh_accu_base <= lut_sh_accu_base;
        b_mp_accu_init <= lut_mp_accu_init;
        b_mp_accu_base <= lut_mp_accu_base;
      end else begin
        a_sh_accu_base <= lut_sh_accu_base;
        a_mp_accu_init <= lut_mp_accu_init;
        a_mp_accu_base <= lut_mp_accu_base;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PE enable of the unit currently on the array, one cycle late. It follows
  // the registered pe_sel, so the source changes in the SWAP cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pe_en <= 1'b0;
    end else begin
      pe_en <= pe_sel ? b_pe_en : a_pe_en;
    end
  end

endmodule

// File: tb/tb_nabp_swap_control.sv
// -----------------------------------------------------------------------------
// tb_nabp_swap_control
//
// Self-checking bench for nabp_swap_control with pNoAngles = 4. A registered
// LUT model answers lut_angle. A transaction-level reference model tracks
// which operation the responder is busy with and when each one started. From
// the documented latencies it derives every output in every cycle, and the
// DUT outputs are compared each cycle at #1 after the rising edge. Directed
// scenarios come first, followed by a randomized phase with two independent
// unit behaviours.
// -----------------------------------------------------------------------------
module tb_nabp_swap_control;

  localparam int N  = 4;
  localparam int AW = 3;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          kick    = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] lut_angle;
  logic [15:0]   lut_sh_accu_base = '0;
  logic [15:0]   lut_mp_accu_init = '0;
  logic [15:0]   lut_mp_accu_base = '0;
  logic          a_swap = 1'b0, a_next_itr = 1'b0, a_pe_en = 1'b0;
  logic          b_swap = 1'b0, b_next_itr = 1'b0, b_pe_en = 1'b0;
  logic          a_swap_ack, a_next_itr_ack, b_swap_ack, b_next_itr_ack;
  logic [15:0]   a_sh_accu_base, a_mp_accu_init, a_mp_accu_base;
  logic [15:0]   b_sh_accu_base, b_mp_accu_init, b_mp_accu_base;
  logic          pe_sel;
  logic          pe_en;

  always #5 clk = ~clk;

  nabp_swap_control #(
    .pNoAngles   (N),
    .pAngleWidth (AW),
    .pShBaseWidth(16),
    .pMpInitWidth(16),
    .pMpBaseWidth(16)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .kick            (kick),
    .busy            (busy),
    .done            (done),
    .lut_angle       (lut_angle),
    .lut_sh_accu_base(lut_sh_accu_base),
    .lut_mp_accu_init(lut_mp_accu_init),
    .lut_mp_accu_base(lut_mp_accu_base),
    .a_swap          (a_swap),
    .a_next_itr      (a_next_itr),
    .a_pe_en         (a_pe_en),
    .a_swap_ack      (a_swap_ack),
    .a_next_itr_ack  (a_next_itr_ack),
    .a_sh_accu_base  (a_sh_accu_base),
    .a_mp_accu_init  (a_mp_accu_init),
    .a_mp_accu_base  (a_mp_accu_base),
    .b_swap          (b_swap),
    .b_next_itr      (b_next_itr),
    .b_pe_en         (b_pe_en),
    .b_swap_ack      (b_swap_ack),
    .b_next_itr_ack  (b_next_itr_ack),
    .b_sh_accu_base  (b_sh_accu_base),
    .b_mp_accu_init  (b_mp_accu_init),
    .b_mp_accu_base  (b_mp_accu_base),
    .pe_sel          (pe_sel),
    .pe_en           (pe_en)
  );

  // LUT contents: word w of angle ang. Word 0 is angle*3, and the other two
  // words are offset so that mixing up the words is visible.
  function automatic logic [15:0] lut_word(input int w, input int ang);
    return 16'(ang * 3 + w * 256);
  endfunction

  // Registered LUT: data for an address appears one cycle later.
  always @(posedge clk) begin
    lut_sh_accu_base <= lut_word(0, int'(lut_angle));
    lut_mp_accu_init <= lut_word(1, int'(lut_angle));
    lut_mp_accu_base <= lut_word(2, int'(lut_angle));
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. The responder handles one operation at a time. An
  // operation begins in a cycle where the responder is free and the request
  // rules select it. Its visible effects follow at fixed offsets from that
  // cycle.
  // ---------------------------------------------------------------------------
  localparam int OP_NONE  = 0;
  localparam int OP_KICK  = 1;
  localparam int OP_FETCH = 2;
  localparam int OP_SWAP  = 3;
  localparam int OP_DONE  = 4;

  bit      m_run     = 1'b0;  // a run is in progress
  int      m_free_at = 0;     // first cycle the responder looks at requests again
  int      m_cnt     = 0;     // angles handed out in this run
  int      op_kind   = OP_NONE;
  int      op_start  = 0;
  int      op_tgt    = 0;
  int      op_angle  = 0;
  bit      rst_seen  = 1'b0;
  logic    p_a_pe_en = 1'b0;
  logic    p_b_pe_en = 1'b0;

  logic          e_busy = 1'b0, e_done = 1'b0, e_sel = 1'b0, e_pe_en = 1'b0;
  logic          e_ack_a = 1'b0, e_ack_b = 1'b0, e_sw = 1'b0;
  logic [AW-1:0] e_lut = '0;
  logic [15:0]   e_par [2][3];

  // Look at the inputs of the current cycle, before the edge that ends it.
  task automatic model_sample();
    p_a_pe_en = a_pe_en;
    p_b_pe_en = b_pe_en;
    rst_seen  = !reset_n;
    if (!reset_n) return;
    if (!m_run) begin
      if (kick) begin
        m_run     = 1'b1;
        m_cnt     = 0;
        op_kind   = OP_KICK;
        op_start  = cyc;
        m_free_at = cyc + 1;
      end
      return;
    end
    if (cyc < m_free_at) return;
    if (m_cnt == N && a_next_itr && b_next_itr) begin
      op_kind   = OP_DONE;
      op_start  = cyc;
      m_free_at = cyc + 1000000;
    end else if (m_cnt < N && (a_next_itr || b_next_itr)) begin
      op_kind   = OP_FETCH;
      op_start  = cyc;
      op_angle  = m_cnt;
      m_cnt++;
      m_free_at = cyc + 4;
      if (a_next_itr && b_next_itr) op_tgt = e_sel ? 0 : 1;
      else                          op_tgt = b_next_itr ? 1 : 0;
    end else if (a_swap && b_swap) begin
      op_kind   = OP_SWAP;
      op_start  = cyc;
      m_free_at = cyc + 2;
    end
  endtask

  // Derive the expected outputs of the cycle that has just begun.
  task automatic model_advance();
    int d;
    e_pe_en = e_sel ? p_b_pe_en : p_a_pe_en;
    e_ack_a = 1'b0;
    e_ack_b = 1'b0;
    e_sw    = 1'b0;
    e_done  = 1'b0;
    if (rst_seen) begin
      m_run   = 1'b0;
      op_kind = OP_NONE;
      e_busy  = 1'b0;
      e_sel   = 1'b0;
      e_pe_en = 1'b0;
      e_lut   = '0;
      for (int u = 0; u < 2; u++)
        for (int w = 0; w < 3; w++) e_par[u][w] = '0;
      return;
    end
    d = cyc - op_start;
    case (op_kind)
      OP_KICK: if (d == 1) begin
        e_busy = 1'b1;
        e_sel  = 1'b0;
      end
      OP_FETCH: begin
        if (d == 1) e_lut = AW'(op_angle);
        if (d == 3) begin
          if (op_tgt == 0) e_ack_a = 1'b1;
          else             e_ack_b = 1'b1;
          for (int w = 0; w < 3; w++) e_par[op_tgt][w] = lut_word(w, op_angle);
        end
      end
      OP_SWAP: if (d == 1) begin
        e_sw  = 1'b1;
        e_sel = ~e_sel;
      end
      OP_DONE: begin
        if (d == 1) e_done = 1'b1;
        if (d == 2) begin
          e_busy  = 1'b0;
          m_run   = 1'b0;
          op_kind = OP_NONE;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check("ctrl{busy,done,nack_a,nack_b,sack_a,sack_b,pe_sel,pe_en}",
          {busy, done, a_next_itr_ack, b_next_itr_ack, a_swap_ack, b_swap_ack, pe_sel, pe_en},
          {e_busy, e_done, e_ack_a, e_ack_b, e_sw, e_sw, e_sel, e_pe_en});
    check("lut_angle", lut_angle, e_lut);
    check("a_params", {a_sh_accu_base, a_mp_accu_init, a_mp_accu_base},
          {e_par[0][0], e_par[0][1], e_par[0][2]});
    check("b_params", {b_sh_accu_base, b_mp_accu_init, b_mp_accu_base},
          {e_par[1][0], e_par[1][1], e_par[1][2]});
  endtask

  // One clock cycle: inputs set by the caller count for the current cycle.
  task automatic step();
    model_sample();
    @(posedge clk);
    #1;
    cyc++;
    model_advance();
    compare_all();
  endtask

  function automatic logic observe(input int which);
    case (which)
      0:       return a_next_itr_ack;
      1:       return b_next_itr_ack;
      2:       return a_swap_ack;
      default: return done;
    endcase
  endfunction

  // Step until the selected output is high, with a bounded number of cycles.
  task automatic wait_for(input string tag, input int which, input int budget, output int at);
    logic seen;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (observe(which)) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    check({tag, "_seen"}, seen, 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic start_run();
    kick = 1'b1;
    step();
    kick = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  bit req_nxt [2];
  bit req_sw  [2];
  int held    [2];

  initial begin
    int t0, at, a_at, b_at, a_cnt, b_cnt, n, acked;

    for (int u = 0; u < 2; u++)
      for (int w = 0; w < 3; w++) e_par[u][w] = '0;

    // Reset values.
    do_reset();
    check("reset_ctrl", {busy, done, lut_angle, a_next_itr_ack, b_next_itr_ack,
                         a_swap_ack, b_swap_ack, pe_sel, pe_en}, '0);
    check("reset_a_params", {a_sh_accu_base, a_mp_accu_init, a_mp_accu_base}, '0);
    check("reset_b_params", {b_sh_accu_base, b_mp_accu_init, b_mp_accu_base}, '0);

    // Single requests from A.
    start_run();
    check("kick_busy", busy, 1'b1);
    t0 = cyc;
    a_next_itr = 1'b1;
    step();
    check("single_lut_angle0", lut_angle, 0);
    wait_for("single_ack0", 0, 8, at);
    a_next_itr = 1'b0;
    check("single_ack0_latency", at - t0, 3);
    check("single_a_sh0", a_sh_accu_base, lut_word(0, 0));
    step();
    t0 = cyc;
    a_next_itr = 1'b1;
    step();
    check("single_lut_angle1", lut_angle, 1);
    wait_for("single_ack1", 0, 8, at);
    a_next_itr = 1'b0;
    check("single_ack1_latency", at - t0, 3);
    check("single_a_params1", {a_sh_accu_base, a_mp_accu_init, a_mp_accu_base},
          {lut_word(0, 1), lut_word(1, 1), lut_word(2, 1)});
    step();

    // Simultaneous requests: the filler (B) goes first.
    do_reset();
    start_run();
    t0 = cyc; a_at = -1; b_at = -1; a_cnt = 0; b_cnt = 0;
    a_next_itr = 1'b1;
    b_next_itr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (a_next_itr_ack) begin a_at = cyc; a_cnt++; a_next_itr = 1'b0; end
      if (b_next_itr_ack) begin b_at = cyc; b_cnt++; b_next_itr = 1'b0; end
    end
    check("sim_b_latency", b_at - t0, 3);
    check("sim_a_latency", a_at - t0, 7);
    check("sim_a_ack_count", a_cnt, 1);
    check("sim_b_ack_count", b_cnt, 1);
    check("sim_b_sh_angle0", b_sh_accu_base, lut_word(0, 0));
    check("sim_a_sh_angle1", a_sh_accu_base, lut_word(0, 1));

    // Swap gating and PE enable source.
    n = 0;
    a_swap = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (a_swap_ack || b_swap_ack) n++;
    end
    check("swap_single_no_ack", n, 0);
    t0 = cyc;
    b_swap = 1'b1;
    wait_for("swap_ack", 2, 6, at);
    check("swap_latency", at - t0, 1);
    check("swap_b_ack_same_cycle", b_swap_ack, 1'b1);
    check("swap_pe_sel", pe_sel, 1'b1);
    a_swap = 1'b0;
    b_swap = 1'b0;
    a_pe_en = 1'b0;
    b_pe_en = 1'b1;
    step();
    check("pe_en_follows_b", pe_en, 1'b1);
    a_pe_en = 1'b1;
    b_pe_en = 1'b0;
    step();
    check("pe_en_ignores_a", pe_en, 1'b0);
    a_pe_en = 1'b0;
    step();

    // Full run: alternating next_itr and swap, then drain.
    do_reset();
    start_run();
    acked = 0;
    for (int i = 0; i < N; i++) begin
      if (i % 2 == 0) a_next_itr = 1'b1;
      else            b_next_itr = 1'b1;
      step();
      check($sformatf("run_lut_angle%0d", i), lut_angle, i);
      wait_for($sformatf("run_ack%0d", i), i % 2, 8, at);
      if (at >= 0) acked++;
      a_next_itr = 1'b0;
      b_next_itr = 1'b0;
      step();
      a_swap = 1'b1;
      b_swap = 1'b1;
      wait_for($sformatf("run_swap%0d", i), 2, 6, at);
      a_swap = 1'b0;
      b_swap = 1'b0;
      step();
    end
    check("run_ack_count", acked, N);
    n = 0;
    a_next_itr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (a_next_itr_ack || b_next_itr_ack) n++;
    end
    check("fifth_no_ack", n, 0);
    b_next_itr = 1'b1;
    wait_for("run_done", 3, 6, at);
    n = (at >= 0) ? 1 : 0;
    a_next_itr = 1'b0;
    b_next_itr = 1'b0;
    step();
    if (done) n++;
    check("done_once", n, 1);
    check("busy_after_done", busy, 1'b0);

    // Reset during FETCH, then restart from angle 0.
    start_run();
    a_next_itr = 1'b1;
    step();
    reset_n    = 1'b0;
    a_next_itr = 1'b0;
    step();
    check("rst_fetch_ctrl", {busy, done, lut_angle, a_next_itr_ack, b_next_itr_ack,
                             a_swap_ack, b_swap_ack, pe_sel, pe_en}, '0);
    check("rst_fetch_a_params", {a_sh_accu_base, a_mp_accu_init, a_mp_accu_base}, '0);
    reset_n = 1'b1;
    start_run();
    a_next_itr = 1'b1;
    step();
    check("restart_lut_angle", lut_angle, 0);
    wait_for("restart_ack", 0, 8, at);
    a_next_itr = 1'b0;
    step();

    // Randomized phase: two independent units, random kicks, PE enables and
    // occasional resets. A unit gives up a request after a long wait so that
    // mixed swap/next_itr holds cannot stall the run for ever.
    for (int u = 0; u < 2; u++) begin
      req_nxt[u] = 1'b0;
      req_sw[u]  = 1'b0;
      held[u]    = 0;
    end
    for (int k = 0; k < 3000; k++) begin
      for (int u = 0; u < 2; u++) begin
        logic got;
        got = (u == 0) ? (a_next_itr_ack | a_swap_ack) : (b_next_itr_ack | b_swap_ack);
        if (got || done || !reset_n) begin
          req_nxt[u] = 1'b0;
          req_sw[u]  = 1'b0;
          held[u]    = 0;
        end else if (req_nxt[u] || req_sw[u]) begin
          held[u]++;
          if (held[u] > 40) begin
            req_nxt[u] = 1'b0;
            req_sw[u]  = 1'b0;
            held[u]    = 0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          if (m_cnt >= N || $urandom_range(0, 1) == 1) req_nxt[u] = 1'b1;
          else                                         req_sw[u]  = 1'b1;
          held[u] = 0;
        end
      end
      a_next_itr = req_nxt[0];
      a_swap     = req_sw[0];
      b_next_itr = req_nxt[1];
      b_swap     = req_sw[1];
      a_pe_en    = 1'($urandom_range(0, 1));
      b_pe_en    = 1'($urandom_range(0, 1));
      kick       = ($urandom_range(0, 5) == 0);
      reset_n    = ($urandom_range(0, 299) != 0);
      step();
    end
    reset_n    = 1'b1;
    kick       = 1'b0;
    a_next_itr = 1'b0;
    b_next_itr = 1'b0;
    a_swap     = 1'b0;
    b_swap     = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
